// File: rtl/banco_registros_pkg.sv
// Shared definitions for the banco_registros register bank:
// move-sequencer states, default sizing and address-width helper.
package banco_registros_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREG  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOV_RD = 2'd1,
    MOV_WR = 2'd2
  } state_t;

  // Address width for n registers, never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/banco_registros_if.sv
// Request/response bundle between the control-unit sequencer (master)
// and the register bank (slave).
interface banco_registros_if
  import banco_registros_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
);
  localparam int AW = calc_aw(NREG);

  logic             save;
  logic [AW-1:0]    save_addr;
  logic [WIDTH-1:0] save_value;
  logic             load;
  logic [AW-1:0]    load_addr;
  logic             mov;
  logic [AW-1:0]    mov_src;
  logic [AW-1:0]    mov_dst;
  logic [WIDTH-1:0] salida;
  logic             salida_valid;
  logic             busy;
  logic             error;

  modport master (
    output save, save_addr, save_value, load, load_addr, mov, mov_src, mov_dst,
    input  salida, salida_valid, busy, error
  );

  modport slave (
    input  save, save_addr, save_value, load, load_addr, mov, mov_src, mov_dst,
    output salida, salida_valid, busy, error
  );

endinterface

// File: rtl/banco_registros_registro_n.sv
// Single WIDTH-bit storage register with write enable and an
// asynchronous active-high reset to a configurable value.
module registro_n #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             save,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: reset to RESET_VAL, load d when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RESET_VAL;
    else if (save) q <= d;
  end

endmodule

// File: rtl/banco_registros.sv
// NREG x WIDTH register bank: address decode, registered read bus,
// two-step register-to-register move sequencer and request error pulse.
// Optional macro BANCO_BYPASS_EN: a same-cycle save and load to the same
// address forwards save_value onto salida (default: read-before-write).
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               NREG      = DEF_NREG,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  banco_registros_if.slave  bus
);

  localparam int AW = calc_aw(NREG);

  logic [WIDTH-1:0] q [NREG];
  logic [NREG-1:0]  we;
  logic [WIDTH-1:0] wr_data;

  state_t           state;
  state_t           state_nx;
  logic             busy;
  logic             mov_rd;
  logic             mov_wr;

  logic [AW-1:0]    src_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] temp;
  logic [WIDTH-1:0] src_data;
  logic [WIDTH-1:0] rd_data;

  logic             mov_ok;
  logic             mov_start;
  logic             save_acc;
  logic             load_acc;
  logic             reject;

  logic [WIDTH-1:0] salida_q;
  logic             valid_q;
  logic             error_q;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  // Request decode: a mov outranks save/load; everything is refused while busy.
  always_comb begin
    mov_ok    = addr_ok(bus.mov_src) && addr_ok(bus.mov_dst);
    mov_start = !busy && bus.mov && mov_ok;
    save_acc  = !busy && !bus.mov && bus.save && addr_ok(bus.save_addr);
    load_acc  = !busy && !bus.mov && bus.load && addr_ok(bus.load_addr);
    if (busy)
      reject = bus.save || bus.load || bus.mov;
    else if (bus.mov)
      reject = bus.save || bus.load || !mov_ok;
    else
      reject = (bus.save && !addr_ok(bus.save_addr)) ||
               (bus.load && !addr_ok(bus.load_addr));
  end

  // Move sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Move sequencer next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mov_start) state_nx = MOV_RD;
      MOV_RD:  state_nx = MOV_WR;
      MOV_WR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Move sequencer outputs.
  always_comb begin
    busy   = (state != IDLE);
    mov_rd = (state == MOV_RD);
    mov_wr = (state == MOV_WR);
  end

  // Latch move operands on acceptance; capture the source in MOV_RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      temp  <= '0;
    end else begin
      if (mov_start) begin
        src_q <= bus.mov_src;
        dst_q <= bus.mov_dst;
      end
      if (mov_rd) temp <= src_data;
    end
  end

  // Write-enable decode; save and move-write never coincide (save is refused while busy).
  always_comb begin
    wr_data = mov_wr ? temp : bus.save_value;
    we      = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      we[i] = (save_acc && (bus.save_addr == AW'(i))) ||
              (mov_wr && (dst_q == AW'(i)));
    end
  end

  // Read muxes for the output bus and the move source.
  always_comb begin
    rd_data  = '0;
    src_data = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bus.load_addr == AW'(i)) rd_data  = q[i];
      if (src_q == AW'(i))         src_data = q[i];
    end
`ifdef BANCO_BYPASS_EN
    if (save_acc && (bus.save_addr == bus.load_addr)) rd_data = bus.save_value;
`else
`endif
  end

  // Registered read bus, valid strobe and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      salida_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valid_q <= load_acc;
      error_q <= reject;
      if (load_acc) salida_q <= rd_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    registro_n #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .save (we[g]),
      .d    (wr_data),
      .q    (q[g])
    );
  end

  assign bus.salida       = salida_q;
  assign bus.salida_valid = valid_q;
  assign bus.busy         = busy;
  assign bus.error        = error_q;

endmodule
